// File: rtl/vscpu_ram_responder.sv
// RAM responder for the VerySimpleCPU: boot loader fills memory, then serves CPU reads/writes.
// Optional CPU write protection of the low PROT_WORDS words: define VSRAM_WRITE_PROTECT_EN.
module vscpu_ram_responder #(
  parameter int unsigned SIZE       = 14,
  parameter int unsigned DEPTH      = 2**SIZE,
  parameter int unsigned PROT_WORDS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [SIZE-1:0] addr_toRAM,
  input  logic [31:0]     data_toRAM,
  output logic [31:0]     data_fromRAM,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  output logic            cpu_rst,
  output logic [SIZE:0]   ld_count,
  output logic            ld_ovf,
  output logic            prot_viol
);

  typedef enum logic [1:0] {LOAD, RELEASE, RUN} state_t;

  state_t            state, state_next;
  logic [SIZE-1:0]   ld_ptr;
  logic [31:0]       mem [DEPTH];
  logic              ld_accept, ld_at_end, prot_hit, cpu_we;
  logic              mem_we;
  logic [SIZE-1:0]   mem_addr;
  logic [31:0]       mem_wdata;

`ifdef VSRAM_WRITE_PROTECT_EN
  assign prot_hit = {{(32-SIZE){1'b0}}, addr_toRAM} < 32'(PROT_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      prot_viol <= 1'b0;
    else if (state == RUN && wrEn && prot_hit)
      prot_viol <= 1'b1;
  end
`else
  assign prot_hit  = 1'b0;
  assign prot_viol = 1'b0;
`endif

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    cpu_rst    = 1'b1;
    ld_accept  = 1'b0;
    ld_at_end  = (ld_ptr == SIZE'(DEPTH - 1));
    cpu_we     = 1'b0;
    unique case (state)
      LOAD: begin
        ld_ready  = 1'b1;
        ld_accept = ld_valid;
        if (ld_valid && (ld_last || ld_at_end))
          state_next = RELEASE;
      end
      RELEASE: state_next = RUN;
      RUN: begin
        cpu_rst = 1'b0;
        cpu_we  = wrEn && !prot_hit;
      end
      default: state_next = LOAD;
    endcase
  end

  // Single memory write port: the loader owns it in LOAD, the CPU in RUN.
  always_comb begin
    mem_we    = ld_accept || cpu_we;
    mem_addr  = ld_accept ? ld_ptr : addr_toRAM;
    mem_wdata = ld_accept ? ld_data : data_toRAM;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LOAD;
      ld_ptr       <= '0;
      ld_count     <= '0;
      ld_ovf       <= 1'b0;
      data_fromRAM <= '0;
    end else begin
      state <= state_next;
      if (ld_accept) begin
        ld_ptr <= ld_ptr + 1'b1;
        if (ld_count != (SIZE+1)'(DEPTH))
          ld_count <= ld_count + 1'b1;
        if (ld_at_end && !ld_last)
          ld_ovf <= 1'b1;
      end
      // Write-first on accepted CPU writes; a dropped write returns the old word.
      if (state == RUN)
        data_fromRAM <= cpu_we ? data_toRAM : mem[addr_toRAM];
    end
  end

endmodule

// File: tb/tb_vscpu_ram_responder.sv
// Directed bench for vscpu_ram_responder (SIZE=5, so overflow and addr 16 are both reachable).
module tb_vscpu_ram_responder;

  localparam int unsigned SIZE = 5;
`ifdef VSRAM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  logic            ld_valid;
  logic            ld_ready;
  logic [31:0]     ld_data;
  logic            ld_last;
  logic            cpu_rst;
  logic [SIZE:0]   ld_count;
  logic            ld_ovf;
  logic            prot_viol;

  int unsigned passed = 0;
  int unsigned total  = 0;

  vscpu_ram_responder #(.SIZE(SIZE), .PROT_WORDS(16)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
    .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_rst(cpu_rst), .ld_count(ld_count),
    .ld_ovf(ld_ovf), .prot_viol(prot_viol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [SIZE-1:0] addr;
    logic [31:0]     data;
    logic [31:0]     exp;
  } vec_t;

  vec_t run_vec [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(ld_count), 0);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_ovf", 32'(ld_ovf), 0);
    check("rst_prot", 32'(prot_viol), 0);
    step();
    rst = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [SIZE-1:0] a, input logic [31:0] d);
    wrEn       = we;
    addr_toRAM = a;
    data_toRAM = d;
    step();
    wrEn = 1'b0;
  endtask

  initial begin
    run_vec[0] = '{1'b0, 5'd0, 32'h0,        32'h10};
    run_vec[1] = '{1'b0, 5'd1, 32'h0,        32'h20};
    run_vec[2] = '{1'b0, 5'd2, 32'h0,        32'h30};
    run_vec[3] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    run_vec[4] = '{1'b0, 5'd2, 32'h0,        32'h30};
    run_vec[5] = '{1'b0, 5'd5, 32'h0,        32'hDEADBEEF};

    rst = 1'b1; wrEn = 1'b0; addr_toRAM = '0; data_toRAM = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    step();

    // Basic load of three words, release, then CPU table.
    do_reset();
    check("load_ready", 32'(ld_ready), 1);
    check("load_dout", data_fromRAM, 0);
    load_word(32'h10, 1'b0);
    load_word(32'h20, 1'b0);
    check("count_2", 32'(ld_count), 2);
    load_word(32'h30, 1'b1);
    check("count_3", 32'(ld_count), 3);
    check("release_cpu_rst", 32'(cpu_rst), 1);
    check("release_ready", 32'(ld_ready), 0);
    step();
    check("run_cpu_rst", 32'(cpu_rst), 0);
    for (int i = 0; i < 6; i++) begin
      cpu_op(run_vec[i].we, run_vec[i].addr, run_vec[i].data);
      check($sformatf("run_vec%0d", i), data_fromRAM, run_vec[i].exp);
    end
    ld_valid = 1'b1; ld_data = 32'hBAD;
    step();
    ld_valid = 1'b0;
    check("run_ignores_ld", 32'(ld_count), 3);
    check("run_ready", 32'(ld_ready), 0);

    // Loader with two idle cycles between words.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_word(32'hA0 + 32'(i), i == 3);
      check($sformatf("gap_count%0d", i), 32'(ld_count), 32'(i + 1));
      if (i < 3) begin
        step(); step();
        check($sformatf("gap_idle%0d", i), 32'(ld_count), 32'(i + 1));
      end
    end
    step();
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b0, SIZE'(i), '0);
      check($sformatf("gap_rd%0d", i), data_fromRAM, 32'hA0 + 32'(i));
    end
    cpu_op(1'b0, 5'd5, '0);
    check("gap_rd5", data_fromRAM, 32'hDEADBEEF);

    // Overflow: fill all 32 words without ld_last.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("ovf_before", 32'(ld_ovf), 0);
      load_word(32'h100 + 32'(i), 1'b0);
    end
    check("ovf_flag", 32'(ld_ovf), 1);
    check("ovf_count", 32'(ld_count), 32);
    check("ovf_release", 32'(cpu_rst), 1);
    step();
    check("ovf_run", 32'(cpu_rst), 0);
    cpu_op(1'b0, 5'd31, '0);
    check("ovf_rd31", data_fromRAM, 32'h11F);

    // CPU writes inside and outside the protected window.
    cpu_op(1'b1, 5'd3, 32'h55);
    check("prot_wr3", data_fromRAM, PROT ? 32'h103 : 32'h55);
    check("prot_flag", 32'(prot_viol), 32'(PROT));
    cpu_op(1'b0, 5'd3, '0);
    check("prot_rd3", data_fromRAM, PROT ? 32'h103 : 32'h55);
    cpu_op(1'b1, 5'd16, 32'h55);
    check("prot_wr16", data_fromRAM, 32'h55);
    cpu_op(1'b0, 5'd16, '0);
    check("prot_rd16", data_fromRAM, 32'h55);

    // Reset mid-load: new load restarts at 0, older words survive.
    do_reset();
    load_word(32'hC0, 1'b0);
    load_word(32'hC1, 1'b0);
    check("mid_count2", 32'(ld_count), 2);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(ld_count), 0);
    check("mid_rst_cpu", 32'(cpu_rst), 1);
    step();
    rst = 1'b1;
    load_word(32'hD0, 1'b1);
    check("mid_count1", 32'(ld_count), 1);
    step();
    cpu_op(1'b0, 5'd0, '0);
    check("mid_rd0", data_fromRAM, 32'hD0);
    cpu_op(1'b0, 5'd1, '0);
    check("mid_rd1", data_fromRAM, 32'hC1);
    cpu_op(1'b0, 5'd2, '0);
    check("mid_rd2", data_fromRAM, 32'h102);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
